// File: rtl/v_nibble_collector_if.sv
// Handshake and slice bus between the V-value slice logic, the nibble
// collector and the stage that consumes the assembled word.
interface v_nibble_collector_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic                   write_enable;
  logic [3:0]             v_plus_new;
  logic [3:0]             v_minus_new;
  logic [4*NIBBLES-1:0]   result;
  logic                   result_valid;
  logic                   result_ready;
  logic                   result_neg;
  logic                   result_zero;
  logic                   busy;
  logic                   overrun;

  // Upstream/downstream environment side: supplies slices and accepts results.
  modport master (
    output start, write_enable, v_plus_new, v_minus_new, result_ready,
    input  result, result_valid, result_neg, result_zero, busy, overrun
  );

  // Collector side.
  modport slave (
    input  start, write_enable, v_plus_new, v_minus_new, result_ready,
    output result, result_valid, result_neg, result_zero, busy, overrun
  );
endinterface

// File: rtl/v_nibble_collector.sv
// Converts LSB-first redundant (plus/minus) 4-bit V slices into a
// two's-complement word by rippling a borrow between slices, then holds
// the word with sign/zero flags until the next stage accepts it.
module v_nibble_collector #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  v_nibble_collector_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_eff;
  logic          borrow_reg, borrow_next, borrow_eff;
  logic [W-1:0]  result_reg, result_next, result_base;
  logic          neg_reg, neg_next;
  logic          zero_reg, zero_next;
  logic          valid_reg, valid_next;
  logic          busy_reg, busy_next;
  logic          overrun_reg, overrun_next;

  logic          start_accept;
  logic          take_slice;
  logic          last_slice;
  logic [4:0]    diff;

  // An accepted start (new frame) restarts the counter, borrow and word so
  // that a slice arriving in the same cycle lands as slice 0.
  assign start_accept = bus.start && ((state_reg != S_HOLD) || bus.result_ready);
  assign take_slice   = bus.write_enable && (start_accept || (state_reg == S_COLLECT));
  assign cnt_eff      = start_accept ? '0 : cnt_reg;
  assign borrow_eff   = start_accept ? 1'b0 : borrow_reg;
  assign result_base  = start_accept ? '0 : result_reg;
  assign diff         = {1'b0, bus.v_plus_new} - {1'b0, bus.v_minus_new} - {4'b0, borrow_eff};
  assign last_slice   = take_slice && (cnt_eff == LAST_IDX);

  // Steer the converted nibble into its slot of the word being assembled.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nibble
    assign result_next[4*gi +: 4] = (take_slice && (cnt_eff == CW'(gi)))
                                    ? diff[3:0] : result_base[4*gi +: 4];
  end

  // Next-state and datapath update decisions.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_eff;
    borrow_next  = borrow_eff;
    neg_next     = start_accept ? 1'b0 : neg_reg;
    zero_next    = start_accept ? 1'b0 : zero_reg;
    overrun_next = overrun_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (start_accept) begin
          state_next = last_slice ? S_HOLD : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (last_slice) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.result_ready) begin
          if (start_accept) begin
            state_next = last_slice ? S_HOLD : S_COLLECT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (take_slice) begin
      cnt_next    = last_slice ? '0 : (cnt_eff + CW'(1));
      borrow_next = diff[4];
    end

    if (last_slice) begin
      neg_next  = diff[4];
      zero_next = (result_next == '0);
    end

    // A slice arriving while the held word blocks is dropped and flagged;
    // only an accepted start clears the flag.
    if (start_accept) begin
      overrun_next = 1'b0;
    end else if ((state_reg == S_HOLD) && bus.write_enable) begin
      overrun_next = 1'b1;
    end

    valid_next = (state_next == S_HOLD);
    busy_next  = (state_next == S_COLLECT);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      borrow_reg  <= 1'b0;
      result_reg  <= '0;
      neg_reg     <= 1'b0;
      zero_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      borrow_reg  <= borrow_next;
      result_reg  <= result_next;
      neg_reg     <= neg_next;
      zero_reg    <= zero_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.result_neg   = neg_reg;
  assign bus.result_zero  = zero_reg;
  assign bus.busy         = busy_reg;
  assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_v_nibble_collector.sv
// Self-checking bench for v_nibble_collector: expected words come from a
// whole-word subtraction model pushed to a scoreboard as frames are driven.
module tb_v_nibble_collector;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] r;
    logic         neg;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  v_nibble_collector_if #(.NIBBLES(NIBBLES)) bus ();

  v_nibble_collector #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word subtraction; the borrow out is the sign.
  task automatic push_expected(input logic [W-1:0] pw, input logic [W-1:0] mw);
    exp_t e;
    logic [W:0] d;
    d = {1'b0, pw} - {1'b0, mw};
    e.r = d[W-1:0];
    e.neg = d[W];
    e.zero = (d[W-1:0] == '0);
    sb_q.push_back(e);
  endtask

  task automatic drive_slice(input logic [3:0] p, input logic [3:0] m, input logic st);
    bus.start = st;
    bus.write_enable = 1'b1;
    bus.v_plus_new = p;
    bus.v_minus_new = m;
    tick();
    bus.start = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] pw, input logic [W-1:0] mw, input int first, input int gap);
    for (int k = first; k < NIBBLES; k++) begin
      drive_slice(pw[4*k +: 4], mw[4*k +: 4], 1'b0);
      if (k < NIBBLES - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.result_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic accept();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected 0", bus.result);
    end
    n_checks++;
    if ({bus.result_valid, bus.result_neg, bus.result_zero, bus.busy, bus.overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v%b n%b z%b b%b o%b expected all 0", bus.result_valid,
               bus.result_neg, bus.result_zero, bus.busy, bus.overrun);
    end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    exp_t e;
    bit ok;
    push_expected(16'h0005, 16'h0003);
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b expected 1", bus.busy);
    end
    feed(16'h0005, 16'h0003, 0, 0);
    n_checks++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: valid=%b busy=%b expected valid=1 busy=0", bus.result_valid, bus.busy);
    end
    wait_valid(ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || {bus.result, bus.result_neg, bus.result_zero} !== {e.r, e.neg, e.zero}) begin
      n_fail++;
      $display("FAIL basic_result: got %h n%b z%b expected %h n%b z%b", bus.result, bus.result_neg,
               bus.result_zero, e.r, e.neg, e.zero);
    end
    $display("frame basic result=%h neg=%b zero=%b", bus.result, bus.result_neg, bus.result_zero);
    accept();
    n_checks++;
    if (bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: valid=%b expected 0", bus.result_valid);
    end
  endtask

  task automatic test_borrow();
    logic [W-1:0] pws [2];
    logic [W-1:0] mws [2];
    exp_t e;
    bit ok;
    pws[0] = 16'h0040; mws[0] = 16'h0001;
    pws[1] = 16'h0000; mws[1] = 16'h0001;
    for (int f = 0; f < 2; f++) begin
      push_expected(pws[f], mws[f]);
      pulse_start();
      feed(pws[f], mws[f], 0, 0);
      wait_valid(ok);
      e = sb_q.pop_front();
      n_checks++;
      if (!ok || {bus.result, bus.result_neg, bus.result_zero} !== {e.r, e.neg, e.zero}) begin
        n_fail++;
        $display("FAIL borrow_result%0d: got %h n%b z%b expected %h n%b z%b", f, bus.result,
                 bus.result_neg, bus.result_zero, e.r, e.neg, e.zero);
      end
      $display("frame borrow%0d result=%h neg=%b zero=%b", f, bus.result, bus.result_neg, bus.result_zero);
      accept();
    end
  endtask

  task automatic test_zero_gaps();
    exp_t e;
    bit ok;
    push_expected(16'h7777, 16'h7777);
    pulse_start();
    drive_slice(4'h7, 4'h7, 1'b0);
    repeat (2) tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0 || bus.result !== 16'h0000) begin
      n_fail++;
      $display("FAIL gap_hold: busy=%b valid=%b result=%h expected busy=1 valid=0 result=0000",
               bus.busy, bus.result_valid, bus.result);
    end
    feed(16'h7777, 16'h7777, 1, 2);
    wait_valid(ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || {bus.result, bus.result_neg, bus.result_zero} !== {e.r, e.neg, e.zero}) begin
      n_fail++;
      $display("FAIL zero_result: got %h n%b z%b expected %h n%b z%b", bus.result, bus.result_neg,
               bus.result_zero, e.r, e.neg, e.zero);
    end
    $display("frame zero result=%h neg=%b zero=%b", bus.result, bus.result_neg, bus.result_zero);
    accept();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa, ma, pb, mb;
    exp_t e;
    bit ok;
    pa = W'($urandom); ma = W'($urandom);
    pb = W'($urandom); mb = W'($urandom);
    push_expected(pa, ma);
    pulse_start();
    feed(pa, ma, 0, 0);
    wait_valid(ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || {bus.result, bus.result_neg, bus.result_zero} !== {e.r, e.neg, e.zero}) begin
      n_fail++;
      $display("FAIL bp_result: got %h n%b z%b expected %h n%b z%b", bus.result, bus.result_neg,
               bus.result_zero, e.r, e.neg, e.zero);
    end
    $display("frame bp_a result=%h neg=%b zero=%b", bus.result, bus.result_neg, bus.result_zero);
    for (int i = 0; i < 5; i++) begin
      drive_slice(4'($urandom), 4'($urandom), 1'b0);
      n_checks++;
      if (bus.result !== e.r || bus.result_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stable%0d: result=%h valid=%b expected %h valid=1", i, bus.result,
                 bus.result_valid, e.r);
      end
    end
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun: got %b expected 1", bus.overrun);
    end
    push_expected(pb, mb);
    bus.result_ready = 1'b1;
    drive_slice(pb[3:0], mb[3:0], 1'b1);
    bus.result_ready = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0 || bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_restart: overrun=%b busy=%b valid=%b expected 0 1 0", bus.overrun,
               bus.busy, bus.result_valid);
    end
    feed(pb, mb, 1, 0);
    wait_valid(ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || {bus.result, bus.result_neg, bus.result_zero} !== {e.r, e.neg, e.zero}) begin
      n_fail++;
      $display("FAIL bp_frame2: got %h n%b z%b expected %h n%b z%b", bus.result, bus.result_neg,
               bus.result_zero, e.r, e.neg, e.zero);
    end
    $display("frame bp_b result=%h neg=%b zero=%b", bus.result, bus.result_neg, bus.result_zero);
    accept();
  endtask

  task automatic test_abort();
    exp_t e;
    bit ok;
    push_expected(16'hA5C3, 16'h3C5A);
    pulse_start();
    drive_slice(4'h0, 4'h9, 1'b0);
    drive_slice(4'hF, 4'h2, 1'b0);
    pulse_start();
    feed(16'hA5C3, 16'h3C5A, 0, 0);
    wait_valid(ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || {bus.result, bus.result_neg, bus.result_zero} !== {e.r, e.neg, e.zero}) begin
      n_fail++;
      $display("FAIL abort_result: got %h n%b z%b expected %h n%b z%b", bus.result, bus.result_neg,
               bus.result_zero, e.r, e.neg, e.zero);
    end
    $display("frame abort result=%h neg=%b zero=%b", bus.result, bus.result_neg, bus.result_zero);
    accept();
  endtask

  task automatic test_reset_midframe();
    pulse_start();
    drive_slice(4'h9, 4'h1, 1'b0);
    drive_slice(4'h6, 4'h2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.result !== '0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: result=%h busy=%b valid=%b expected 0 0 0", bus.result,
               bus.busy, bus.result_valid);
    end
    tick();
    rst_n = 1'b1;
    feed(16'h1234, 16'h0001, 0, 0);
    tick();
    n_checks++;
    if (bus.result !== '0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_start: result=%h busy=%b valid=%b expected 0 0 0", bus.result,
               bus.busy, bus.result_valid);
    end
    $display("reset mid-frame done");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.write_enable = 1'b0;
    bus.v_plus_new = '0;
    bus.v_minus_new = '0;
    bus.result_ready = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_zero_gaps();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
